tone_sequencer: RTL and testbench

- Plays a stored melody.
- Holds a small note table. Each entry is a half-period and a duration.
- Steps through the table entry by entry and drives one built-in square-wave tone generator.
- Sits between a host or control logic, which loads notes and issues start/stop, and the audio output pin. It replaces the fixed-period tone instances used so far with a sequenced one.

---
 rtl/tone_sequencer.sv | 177 +++++++++++++++++
 tb/tb_tone_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// Note-table melody sequencer driving a built-in square-wave tone generator.
// Entries are {half-period, duration in ticks}; playback walks 0..last_addr.
module tone_sequencer #(
  parameter int PW        = 16,
  parameter int DW        = 16,
  parameter int AW        = 4,
  parameter int TICK_DIV  = 32000,
  parameter int GAP_TICKS = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [PW-1:0] wr_period,
  input  logic [DW-1:0] wr_dur,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  input  logic [AW-1:0] last_addr,
  output logic          busy,
  output logic [AW-1:0] cur_addr,
  output logic [PW-1:0] period_out,
  output logic          tone_out,
  output logic          done
);

  localparam int TW = $clog2(TICK_DIV + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP
  } state_t;

  state_t r_state, w_nxt;

  logic [PW-1:0] r_mem_per [2**AW];
  logic [DW-1:0] r_mem_dur [2**AW];
  logic [PW-1:0] r_rd_per;
  logic [DW-1:0] r_rd_dur;

  logic [AW-1:0] r_addr, w_nxt_addr;
  logic [TW-1:0] r_tick;
  logic [DW-1:0] r_dcnt, r_dur;
  logic [PW-1:0] r_per, r_half;
  logic          r_tone, r_done;

  logic w_wrap, w_adv, w_enter_play, w_enter_gap;
  logic w_done, w_timed, w_stay_play, w_tone_run;

  always_comb begin
    w_wrap       = (r_tick == TW'(TICK_DIV - 1));
    w_nxt        = r_state;
    w_nxt_addr   = r_addr;
    w_adv        = 1'b0;
    w_enter_play = 1'b0;
    w_enter_gap  = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_nxt      = S_LOAD;
          w_nxt_addr = '0;
        end
      end
      S_LOAD: begin
        if (stop) begin
          w_nxt = S_IDLE;
        end else if (r_rd_dur == '0) begin
          w_adv = 1'b1;
        end else begin
          w_nxt        = S_PLAY;
          w_enter_play = 1'b1;
        end
      end
      S_PLAY: begin
        if (stop) begin
          w_nxt = S_IDLE;
        end else if (w_wrap && r_dcnt == r_dur - 1'b1) begin
          if (GAP_TICKS > 0) begin
            w_nxt       = S_GAP;
            w_enter_gap = 1'b1;
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (stop) begin
          w_nxt = S_IDLE;
        end else if (w_wrap && r_dcnt == DW'(GAP_TICKS - 1)) begin
          w_adv = 1'b1;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
    // loop and last_addr are sampled only here, at the advance cycle
    if (w_adv) begin
      if (r_addr != last_addr) begin
        w_nxt      = S_LOAD;
        w_nxt_addr = r_addr + 1'b1;
      end else if (loop) begin
        w_nxt      = S_LOAD;
        w_nxt_addr = '0;
      end else begin
        w_nxt  = S_IDLE;
        w_done = 1'b1;
      end
    end
  end

  assign w_timed     = (w_nxt == S_PLAY) || (w_nxt == S_GAP);
  assign w_stay_play = (r_state == S_PLAY) && (w_nxt == S_PLAY);
  assign w_tone_run  = w_stay_play && (r_per != '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_done  <= 1'b0;
      r_tick  <= '0;
      r_dcnt  <= '0;
      r_dur   <= '0;
      r_per   <= '0;
      r_half  <= '0;
      r_tone  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_addr  <= w_nxt_addr;
      r_done  <= w_done;
      if (w_enter_play || w_enter_gap || !w_timed) begin
        r_tick <= '0;
        r_dcnt <= '0;
      end else if (w_wrap) begin
        r_tick <= '0;
        r_dcnt <= r_dcnt + 1'b1;
      end else begin
        r_tick <= r_tick + 1'b1;
      end
      if (w_enter_play) begin
        r_dur <= r_rd_dur;
        r_per <= r_rd_per;
      end else if (!w_stay_play) begin
        r_per <= '0;
      end
      if (w_tone_run) begin
        if (r_half == r_per - 1'b1) begin
          r_half <= '0;
          r_tone <= ~r_tone;
        end else begin
          r_half <= r_half + 1'b1;
        end
      end else begin
        r_half <= '0;
        r_tone <= 1'b0;
      end
    end
  end

  // Read address follows the next entry so data is ready during LOAD
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      r_mem_per[wr_addr] <= wr_period;
      r_mem_dur[wr_addr] <= wr_dur;
    end
    r_rd_per <= r_mem_per[w_nxt_addr];
    r_rd_dur <= r_mem_dur[w_nxt_addr];
  end

  assign busy       = (r_state != S_IDLE);
  assign cur_addr   = r_addr;
  assign period_out = r_per;
  assign tone_out   = r_tone;
  assign done       = r_done;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: vector table, timeline reference model,
// randomized melodies and hand-written corner sequences.
module tb_tone_sequencer;

  localparam int TD  = 4;
  localparam int GAP = 1;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_period = '0;
  logic [15:0] wr_dur = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [3:0]  last_addr = '0;
  logic        busy;
  logic [3:0]  cur_addr;
  logic [15:0] period_out;
  logic        tone_out;
  logic        done;

  tone_sequencer #(
    .PW(16), .DW(16), .AW(4), .TICK_DIV(TD), .GAP_TICKS(GAP)
  ) dut (
    .CLK(CLK), .RST(RST),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_period(wr_period), .wr_dur(wr_dur),
    .start(start), .stop(stop), .loop(loop),
    .last_addr(last_addr),
    .busy(busy), .cur_addr(cur_addr),
    .period_out(period_out), .tone_out(tone_out),
    .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        b;
    logic [3:0]  a;
    logic [15:0] p;
    logic        t;
    logic        d;
  } obs_t;

  typedef struct {
    int per;
    int dur;
    int busy_n;
    int rises;
  } vec_t;

  obs_t w_o;
  assign w_o = {busy, cur_addr, period_out, tone_out, done};

  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_per [16];
  int   m_dur [16];
  obs_t exp_q [$];
  vec_t vt [6];

  function automatic obs_t mk(logic b, int a, int p, logic t, logic d);
    obs_t o;
    o.b = b; o.a = 4'(a); o.p = 16'(p); o.t = t; o.d = d;
    return o;
  endfunction

  task automatic chk(string nm, int idx, obs_t act, obs_t ex);
    n_cmp++;
    if (act !== ex) begin
      n_bad++;
      $display("FAIL %s[%0d] got b=%0b a=%0d p=%0d t=%0b d=%0b want b=%0b a=%0d p=%0d t=%0b d=%0b",
               nm, idx, act.b, act.a, act.p, act.t, act.d,
               ex.b, ex.a, ex.p, ex.t, ex.d);
    end
  endtask

  task automatic chk_int(string nm, int idx, int act, int ex);
    n_cmp++;
    if (act != ex) begin
      n_bad++;
      $display("FAIL %s[%0d] got %0d want %0d", nm, idx, act, ex);
    end
  endtask

  task automatic wr(int a, int p, int d);
    wr_en = 1'b1; wr_addr = 4'(a);
    wr_period = 16'(p); wr_dur = 16'(d);
    m_per[a] = p; m_dur[a] = d;
    @(negedge CLK);
    wr_en = 1'b0;
  endtask

  // Expected per-cycle timeline of a non-looping melody, from start edge on
  task automatic build_trace(int last);
    exp_q.delete();
    for (int a = 0; a <= last; a++) begin
      exp_q.push_back(mk(1, a, 0, 0, 0));
      if (m_dur[a] != 0) begin
        for (int k = 0; k < m_dur[a] * TD; k++)
          exp_q.push_back(mk(1, a, m_per[a],
            (m_per[a] == 0) ? 1'b0 : 1'((k / m_per[a]) % 2), 0));
        for (int k = 0; k < GAP * TD; k++)
          exp_q.push_back(mk(1, a, 0, 0, 0));
      end
    end
    exp_q.push_back(mk(0, last, 0, 0, 1));
    exp_q.push_back(mk(0, last, 0, 0, 0));
  endtask

  // hook >= 0: rewrite entry1 period to 6 and pulse start while busy
  task automatic run_trace(string nm, int last, int hook);
    last_addr = 4'(last);
    loop = 1'b0;
    build_trace(last);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk(nm, i, w_o, exp_q[i]);
      if (i == hook) begin
        wr_en = 1'b1; wr_addr = 4'd1;
        wr_period = 16'd6; wr_dur = 16'd2;
        start = 1'b1;
      end else if (hook >= 0 && i == hook + 1) begin
        wr_en = 1'b0; start = 1'b0;
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    int bn, rs, dn, cyc;
    logic pt;
    vt[0] = '{3, 2, 13, 1};
    vt[1] = '{1, 1, 9, 2};
    vt[2] = '{0, 3, 17, 0};
    vt[3] = '{5, 0, 1, 0};
    vt[4] = '{2, 3, 17, 3};
    vt[5] = '{6, 2, 13, 1};

    #3;
    chk("reset", 0, w_o, mk(0, 0, 0, 0, 0));
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("idle", 0, w_o, mk(0, 0, 0, 0, 0));

    foreach (vt[v]) begin
      wr(0, vt[v].per, vt[v].dur);
      last_addr = 4'd0; loop = 1'b0;
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      bn = 0; rs = 0; dn = 0; pt = 1'b0; cyc = 0;
      while (cyc < 100) begin
        if (busy) bn++;
        if (tone_out && !pt) rs++;
        pt = tone_out;
        if (done) dn++;
        if (!busy) break;
        @(negedge CLK);
        cyc++;
      end
      @(negedge CLK);
      if (done) dn++;
      chk_int("vec_busy", v, bn, vt[v].busy_n);
      chk_int("vec_rises", v, rs, vt[v].rises);
      chk_int("vec_done", v, dn, 1);
    end

    wr(0, 3, 2);
    run_trace("single", 0, -1);

    wr(0, 5, 1); wr(1, 0, 2); wr(2, 7, 0); wr(3, 2, 1);
    run_trace("restskip", 3, -1);

    wr(0, 2, 1); wr(1, 3, 1);
    last_addr = 4'd1; loop = 1'b1;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i <= 54; i++) begin
      if (i < 54) chk("loop", i, w_o, mk(1, (i / 9) % 2, w_o.p, w_o.t, 0));
      else        chk("loop", i, w_o, mk(0, 1, 0, 0, 1));
      if (i == 47) loop = 1'b0;
      @(negedge CLK);
    end

    wr(0, 2, 1); wr(1, 4, 2);
    last_addr = 4'd1;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i == 12) stop = 1'b1;
      @(negedge CLK);
    end
    stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stop", i, w_o, mk(0, 1, 0, 0, 0));
      @(negedge CLK);
    end
    start = 1'b1; stop = 1'b1;
    @(negedge CLK);
    start = 1'b0; stop = 1'b0;
    chk("startstop", 0, w_o, mk(0, 1, 0, 0, 0));
    @(negedge CLK);
    chk("startstop", 1, w_o, mk(0, 1, 0, 0, 0));

    wr(0, 4, 2); wr(1, 4, 2);
    m_per[1] = 6;
    run_trace("wrplay", 1, 3);

    last_addr = 4'd1;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge CLK);
    chk("prerst", 0, w_o, mk(1, 0, 4, 1, 0));
    #2 RST = 1'b1;
    #1 chk("asyncrst", 0, w_o, mk(0, 0, 0, 0, 0));
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    run_trace("replay", 1, -1);

    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 4; a++)
        wr(a, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
      run_trace("rand", int'($urandom_range(0, 3)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
